// File: rtl/jpeg_mcu_enc_if.sv
// Coefficient input and Huffman symbol output bundle of the MCU encoder.
// The master side is the encoder; the slave side is its environment.
interface jpeg_mcu_enc_if;
    logic        inport_valid_i;
    logic [15:0] inport_data_i;
    logic [1:0]  inport_type_i;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic        outport_accept_i;
    logic [1:0]  outport_table_o;
    logic [7:0]  outport_symbol_o;
    logic [15:0] outport_bits_o;
    logic [4:0]  outport_width_o;
    logic        outport_eob_o;

    modport master (
        input  inport_valid_i, inport_data_i, inport_type_i, outport_accept_i,
        output inport_accept_o, outport_valid_o, outport_table_o, outport_symbol_o,
               outport_bits_o, outport_width_o, outport_eob_o
    );

    modport slave (
        output inport_valid_i, inport_data_i, inport_type_i, outport_accept_i,
        input  inport_accept_o, outport_valid_o, outport_table_o, outport_symbol_o,
               outport_bits_o, outport_width_o, outport_eob_o
    );
endinterface

// File: rtl/jpeg_mcu_enc.sv
// Baseline JPEG coefficient-to-symbol encoder: DC prediction, AC zero runs,
// ZRL insertion and EOB generation into a single registered output slot.
module jpeg_mcu_enc (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           img_start_i,
    jpeg_mcu_enc_if.master bus
);
    typedef enum logic [0:0] {
        STATE_IDLE = 1'b0,
        STATE_ZRL  = 1'b1
    } state_t;

    state_t      state;
    logic [5:0]  pos_q;
    logic [5:0]  run_q;
    logic [1:0]  type_q;
    logic [15:0] prev_dc [0:2];
    logic [15:0] pend_q;
    logic        pend_last_q;

    logic        slot_free;
    logic        accept;
    logic        coef_fire;
    logic [1:0]  dc_idx;
    logic [15:0] diff;
    logic [3:0]  dc_size;
    logic [3:0]  ac_size;
    logic [3:0]  pend_size;

    logic        ld_en;
    logic [1:0]  ld_table;
    logic [7:0]  ld_symbol;
    logic [15:0] ld_bits;
    logic [4:0]  ld_width;
    logic        ld_eob;

    // 0x8000 has no 15-bit magnitude; it is pinned to size 15 so the output stays deterministic
    function automatic logic [3:0] amp_size(input logic [15:0] v);
        logic [15:0] mag;
        logic [3:0]  s;
        mag = v[15] ? (~v + 16'd1) : v;
        s   = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mag[i]) s = 4'(i + 1);
        end
        if (v == 16'h8000) s = 4'd15;
        return s;
    endfunction

    function automatic logic [15:0] amp_bits(input logic [15:0] v, input logic [3:0] s);
        logic [15:0] mask;
        logic [15:0] raw;
        mask = (16'd1 << s) - 16'd1;
        raw  = v[15] ? (v - 16'd1) : v;
        if (v == 16'h8000) raw = 16'd0;
        return raw & mask;
    endfunction

    // Handshake, predictor selection and amplitude sizing
    always_comb begin
        slot_free = !bus.outport_valid_o || bus.outport_accept_i;
        accept    = rst_i && (state == STATE_IDLE) && slot_free && !img_start_i;
        coef_fire = accept && bus.inport_valid_i;
        case (bus.inport_type_i)
            2'd0:    dc_idx = 2'd0;
            2'd1:    dc_idx = 2'd1;
            default: dc_idx = 2'd2;
        endcase
        diff      = bus.inport_data_i - prev_dc[dc_idx];
        dc_size   = amp_size(diff);
        ac_size   = amp_size(bus.inport_data_i);
        pend_size = amp_size(pend_q);
    end

    assign bus.inport_accept_o = accept;

    // Symbol to load into the output slot this cycle
    always_comb begin
        ld_en     = 1'b0;
        ld_table  = {(type_q != 2'd0), 1'b1};
        ld_symbol = 8'h00;
        ld_bits   = 16'h0000;
        ld_width  = 5'd0;
        ld_eob    = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (!coef_fire) begin
                    ld_en = 1'b0;
                end else if (pos_q == 6'd0) begin
                    ld_en     = 1'b1;
                    ld_table  = {(bus.inport_type_i != 2'd0), 1'b0};
                    ld_symbol = {4'h0, dc_size};
                    ld_bits   = amp_bits(diff, dc_size);
                    ld_width  = {1'b0, dc_size};
                end else if (bus.inport_data_i == 16'h0000) begin
                    ld_en  = (pos_q == 6'd63);
                    ld_eob = (pos_q == 6'd63);
                end else if (run_q >= 6'd16) begin
                    ld_en     = 1'b1;
                    ld_symbol = 8'hF0;
                end else begin
                    ld_en     = 1'b1;
                    ld_symbol = {run_q[3:0], ac_size};
                    ld_bits   = amp_bits(bus.inport_data_i, ac_size);
                    ld_width  = {1'b0, ac_size};
                    ld_eob    = (pos_q == 6'd63);
                end
            end
            STATE_ZRL: begin
                if (!slot_free) begin
                    ld_en = 1'b0;
                end else if (run_q >= 6'd16) begin
                    ld_en     = 1'b1;
                    ld_symbol = 8'hF0;
                end else begin
                    ld_en     = 1'b1;
                    ld_symbol = {run_q[3:0], pend_size};
                    ld_bits   = amp_bits(pend_q, pend_size);
                    ld_width  = {1'b0, pend_size};
                    ld_eob    = pend_last_q;
                end
            end
            default: ld_en = 1'b0;
        endcase
    end

    // Block sequencing FSM, DC predictors and the output slot
    always_ff @(posedge clk_i) begin
        if (!rst_i || img_start_i) begin
            state                <= STATE_IDLE;
            pos_q                <= 6'd0;
            run_q                <= 6'd0;
            type_q               <= 2'd0;
            pend_q               <= 16'h0000;
            pend_last_q          <= 1'b0;
            prev_dc[0]           <= 16'h0000;
            prev_dc[1]           <= 16'h0000;
            prev_dc[2]           <= 16'h0000;
            bus.outport_valid_o  <= 1'b0;
            bus.outport_table_o  <= 2'd0;
            bus.outport_symbol_o <= 8'h00;
            bus.outport_bits_o   <= 16'h0000;
            bus.outport_width_o  <= 5'd0;
            bus.outport_eob_o    <= 1'b0;
        end else begin
            if (ld_en) begin
                bus.outport_valid_o  <= 1'b1;
                bus.outport_table_o  <= ld_table;
                bus.outport_symbol_o <= ld_symbol;
                bus.outport_bits_o   <= ld_bits;
                bus.outport_width_o  <= ld_width;
                bus.outport_eob_o    <= ld_eob;
            end else if (slot_free) begin
                bus.outport_valid_o <= 1'b0;
            end else begin
                bus.outport_valid_o <= bus.outport_valid_o;
            end
            case (state)
                STATE_IDLE: begin
                    if (coef_fire) begin
                        // 6-bit counter wraps 63 -> 0 onto the next DC beat
                        pos_q <= pos_q + 6'd1;
                        if (pos_q == 6'd0) begin
                            type_q          <= bus.inport_type_i;
                            prev_dc[dc_idx] <= bus.inport_data_i;
                            run_q           <= 6'd0;
                        end else if (bus.inport_data_i == 16'h0000) begin
                            run_q <= (pos_q == 6'd63) ? 6'd0 : run_q + 6'd1;
                        end else if (run_q >= 6'd16) begin
                            run_q       <= run_q - 6'd16;
                            pend_q      <= bus.inport_data_i;
                            pend_last_q <= (pos_q == 6'd63);
                            state       <= STATE_ZRL;
                        end else begin
                            run_q <= 6'd0;
                        end
                    end
                end
                STATE_ZRL: begin
                    if (slot_free) begin
                        if (run_q >= 6'd16) begin
                            run_q <= run_q - 6'd16;
                        end else begin
                            run_q <= 6'd0;
                            state <= STATE_IDLE;
                        end
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end
endmodule

// File: doc/jpeg_mcu_enc.md
# jpeg_mcu_enc

Coefficient-to-symbol encoder for the baseline JPEG path, performing the inverse of the MCU coefficient decoder. It takes 64 quantised coefficients per 8x8 block in zigzag order and performs DC prediction, AC zero-run counting, ZRL insertion and EOB generation. For each block it emits Huffman symbols (run/size byte plus amplitude bits and the DHT table index) to the downstream Huffman coder and bit packer.

## Interface
Parameters: none.
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-low
- img_start_i  in  1  start of image; clears DC predictors and aborts any block in progress
- inport_valid_i  in  1  coefficient valid
- inport_data_i  in  16  signed quantised coefficient, zigzag order
- inport_type_i  in  2  block type (0=Y, 1=Cb, 2=Cr; 3 treated as Cr); sampled on the DC beat
- inport_accept_o  out  1  coefficient accepted when valid && accept
- outport_valid_o  out  1  symbol valid
- outport_accept_i  in  1  downstream accepts symbol
- outport_table_o  out  2  DHT index (0=Y DC, 1=Y AC, 2=Cx DC, 3=Cx AC)
- outport_symbol_o  out  8  Huffman symbol: {run[3:0], size[3:0]}
- outport_bits_o  out  16  amplitude bits, right-aligned, zero above width
- outport_width_o  out  5  amplitude width (= size, 0..15)
- outport_eob_o  out  1  last symbol of the block

## Operation
- Internal position counter pos_q (0..63) increments on every accepted coefficient and wraps 63->0. pos_q==0 is the DC beat.
- Block type latched as type_q on the DC beat. Cx tables are used when type_q != 0.
- DC beat:
  - diff = data - prev_dc[type] (16-bit wrap).
  - prev_dc[type] <= data.
  - Emit symbol {0, size(diff)} on the DC table.
- AC beats: a zero coefficient increments run_q. A nonzero coefficient proceeds as follows:
  - While run_q >= 16, emit ZRL (0xF0, width 0) and subtract 16 from run_q.
  - Then emit {run_q, size(v)} and clear run_q.
- size(v): bit length of |v|, where |v| is 16-bit magnitude. v=0 gives 0. v=0x8000 gives size 15, bits 0 (deterministic, out of baseline range).
- Amplitude bits:
  - v>0: v[size-1:0].
  - v<0: (v-1)[size-1:0], i.e. one's complement.
  - This is the exact inverse of the decoder's decode_number.
- Position 63:
  - If the coefficient is nonzero, its symbol carries outport_eob_o=1 and no EOB symbol is emitted.
  - If it is zero, emit EOB 0x00 (AC table, width 0, eob=1). Pending trailing zeros never produce ZRLs.
- FSM:
  - STATE_IDLE: accept coefficients. A nonzero AC with run_q>=16 latches the coefficient and moves to STATE_ZRL.
  - STATE_ZRL: inport_accept_o=0. One ZRL is loaded each time the output slot frees. When run_q<16, load the latched coefficient's symbol and return to STATE_IDLE.
- Output register: a single slot. The slot is free when !outport_valid_o || outport_accept_i.
- inport_accept_o = (state==STATE_IDLE) && slot free && !img_start_i.
- Zero AC beats that produce no symbol are still gated by the slot-free condition. This keeps the logic simple and accepts the throughput cost.
- img_start_i has priority over every other event:
  - pos_q, run_q and all prev_dc are cleared.
  - FSM returns to STATE_IDLE.
  - outport_valid_o is cleared, discarding any pending symbol.

## Timing
- Reset (rst_i=0 at a clk edge) values:
  - outport_valid_o=0, outport_eob_o=0, outport_symbol_o=0, outport_bits_o=0, outport_width_o=0, outport_table_o=0.
  - inport_accept_o=0 during reset and 1 on the first cycle after.
  - pos_q=0, run_q=0, prev_dc=0, state=STATE_IDLE.
- Latency: a symbol appears in the cycle after the accepting edge (registered output, 1 cycle).
- Output fields hold stable while outport_valid_o && !outport_accept_i.
- Throughput:
  - One coefficient per cycle under continuous accept.
  - Each ZRL costs one input stall cycle.
  - The run-of-62 worst case stalls 3 cycles.
- Simultaneous output accept and new load in the same cycle: new symbol replaces the old with no bubble.
- Reset or img_start_i mid-block: the partial block is discarded. The next accepted coefficient is treated as DC with predictor 0.

## Test plan
- All-zero Y block after reset -> Y DC table (0): symbol 0x00, width 0; then Y AC table (1): symbol 0x00, eob=1; exactly 2 symbols.
- Two Y blocks, DC=5 then DC=3, AC zero -> first DC symbol 0x03 with bits 0b101; second block diff -2 gives symbol 0x02 with bits 0b01; each followed by EOB.
- Cb block, DC=0, idx1=-1, rest zero -> table 2 symbol 0x00; table 3 symbol 0x01 with bits 0 and width 1; table 3 EOB with eob=1.
- Y block with idx1..20 zero and idx21=7 -> ZRL 0xF0 then symbol 0x43 with bits 0b111; inport_accept_o low exactly 1 cycle.
- Y block with idx1..62 zero and idx63=1 -> 3x ZRL, then symbol 0xE1 with bits 1 and eob=1; no EOB symbol emitted.
- Stress: outport_accept_i held low 5 cycles, outputs stable and inport_accept_o=0; img_start_i asserted mid-block clears valid, and the next block's DC is encoded against predictor 0.
